// File: rtl/rdma_sq_cq_scheduler_pkg.sv
// Shared request/ack layouts and scheduler state encoding for the RDMA SQ/CQ slice.
package lynxTypes;
   localparam int unsigned N_REGIONS_BITS = 4;

   typedef struct packed {
      logic [255-N_REGIONS_BITS:0] body;
      logic [N_REGIONS_BITS-1:0]   vfid;
   } dreq_t;

   typedef struct packed {
      logic [31-N_REGIONS_BITS:0] body;
      logic [N_REGIONS_BITS-1:0]  vfid;
   } ack_t;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} sched_state_t;
endpackage

// File: rtl/rdma_sq_cq_scheduler_arbiter.sv
// Combinational rotating-priority pick: first eligible index at or after rr_ptr.
module rdma_rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   int unsigned j;
   logic [IW-1:0] j_idx;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      j_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(rr_ptr) + k;
         if (j >= N) j = j - N;
         j_idx = IW'(j);
         if (!any && eligible[j_idx]) begin
            any          = 1'b1;
            idx          = j_idx;
            grant[j_idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rdma_sq_cq_scheduler.sv
// Shares the network RDMA SQ among vFPGA requesters with per-requester credits,
// and demultiplexes network acks back to the owning requester.
module rdma_sq_cq_scheduler
   import lynxTypes::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned SQ_BITS  = 256,
   parameter int unsigned CQ_BITS  = 32,
   parameter int unsigned VFID_LSB = 0,
   parameter int unsigned MAX_OUTS = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [N_REQ-1:0]         s_sq_valid,
   output logic [N_REQ-1:0]         s_sq_ready,
   input  logic [N_REQ*SQ_BITS-1:0] s_sq_data,
   output logic                     m_sq_valid,
   input  logic                     m_sq_ready,
   output logic [SQ_BITS-1:0]       m_sq_data,
   input  logic                     s_cq_valid,
   output logic                     s_cq_ready,
   input  logic [CQ_BITS-1:0]       s_cq_data,
   output logic [N_REQ-1:0]         m_cq_valid,
   input  logic [N_REQ-1:0]         m_cq_ready,
   output logic [CQ_BITS-1:0]       m_cq_data,
   input  logic                     drain_req,
   output logic                     drained,
   output logic [1:0]               err_sticky
);
   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTS) + 1;

   sched_state_t              state, state_nxt;
   logic [CW-1:0]             cnt [N_REQ];
   logic [IW-1:0]             rr_ptr, win_idx;
   logic [N_REQ-1:0]          eligible, win_onehot, ack_fire;
   logic                      win_any, grant_en, out_valid, cnt_zero, underflow;
   logic                      cq_in_range, cq_ready_sel;
   logic [SQ_BITS-1:0]        out_data, stamped;
   logic [N_REGIONS_BITS-1:0] cq_vfid;
   logic [1:0]                err;

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < N_REQ; i++)
         eligible[i] = s_sq_valid[i] && (cnt[i] < CW'(MAX_OUTS)) && (state == ST_RUN);
   end

   rdma_rr_arbiter #(.N(N_REQ)) u_arb (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .grant    (win_onehot),
      .idx      (win_idx),
      .any      (win_any)
   );

   // A grant may refill the output register in the same cycle it drains.
   assign grant_en   = win_any && (!out_valid || m_sq_ready);
   assign s_sq_ready = grant_en ? win_onehot : '0;
   assign m_sq_valid = out_valid;
   assign m_sq_data  = out_data;

   always_comb begin
      stamped = s_sq_data[win_idx*SQ_BITS +: SQ_BITS];
      stamped[VFID_LSB +: N_REGIONS_BITS] = N_REGIONS_BITS'(win_idx);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         rr_ptr    <= '0;
      end else if (grant_en) begin
         out_valid <= 1'b1;
         out_data  <= stamped;
         rr_ptr    <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (m_sq_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign cq_vfid     = s_cq_data[VFID_LSB +: N_REGIONS_BITS];
   assign cq_in_range = ({1'b0, cq_vfid} < (N_REGIONS_BITS + 1)'(N_REQ));
   assign s_cq_ready  = cq_in_range ? cq_ready_sel : 1'b1;
   assign m_cq_data   = s_cq_data;
   assign ack_fire    = m_cq_valid & m_cq_ready;

   always_comb begin
      m_cq_valid   = '0;
      cq_ready_sel = 1'b0;
      underflow    = 1'b0;
      cnt_zero     = 1'b1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (cq_vfid == N_REGIONS_BITS'(i)) begin
            m_cq_valid[i] = s_cq_valid;
            cq_ready_sel  = m_cq_ready[i];
         end
         if (cnt[i] != '0) cnt_zero = 1'b0;
      end
      for (int unsigned i = 0; i < N_REQ; i++)
         if (ack_fire[i] && cnt[i] == '0) underflow = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
         err <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (s_sq_ready[i] && !ack_fire[i])
               cnt[i] <= cnt[i] + 1'b1;
            else if (ack_fire[i] && !s_sq_ready[i] && cnt[i] != '0)
               cnt[i] <= cnt[i] - 1'b1;
         end
         if (underflow) err[0] <= 1'b1;
         if (s_cq_valid && !cq_in_range) err[1] <= 1'b1;
      end
   end
   assign err_sticky = err;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= ST_RUN;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (drain_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (!drain_req) state_nxt = ST_RUN;
                   else if (!out_valid && cnt_zero) state_nxt = ST_IDLE;
         ST_IDLE:  if (!drain_req) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end
   assign drained = (state == ST_IDLE);
endmodule

// File: tb/tb_rdma_sq_cq_scheduler.sv
// Randomized and directed checks of the SQ/CQ scheduler against a queue-level reference model.
module tb_rdma_sq_cq_scheduler;
   localparam int N   = 4;
   localparam int SQB = 256;
   localparam int CQB = 32;
   localparam int MO  = 16;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic [N-1:0]     s_sq_valid, s_sq_ready;
   logic [N*SQB-1:0] s_sq_data;
   logic             m_sq_valid, m_sq_ready;
   logic [SQB-1:0]   m_sq_data;
   logic             s_cq_valid, s_cq_ready;
   logic [CQB-1:0]   s_cq_data;
   logic [N-1:0]     m_cq_valid, m_cq_ready;
   logic [CQB-1:0]   m_cq_data;
   logic             drain_req, drained;
   logic [1:0]       err_sticky;

   rdma_sq_cq_scheduler #(.N_REQ(N), .SQ_BITS(SQB), .CQ_BITS(CQB), .VFID_LSB(0), .MAX_OUTS(MO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
      .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
      .s_cq_valid(s_cq_valid), .s_cq_ready(s_cq_ready), .s_cq_data(s_cq_data),
      .m_cq_valid(m_cq_valid), .m_cq_ready(m_cq_ready), .m_cq_data(m_cq_data),
      .drain_req(drain_req), .drained(drained), .err_sticky(err_sticky)
   );

   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: credits, rotating pointer, one-deep output slot, quiesce mode (0 run, 1 drain, 2 idle).
   int             mcnt [N];
   int             rr;
   bit             mvalid;
   logic [SQB-1:0] mdata;
   int             mode;
   logic [1:0]     merr;
   logic [N-1:0]   last_ready;
   logic           last_cq_ready;
   logic [N-1:0]   got_ready;
   logic           got_drained;
   logic [1:0]     got_err;
   logic [SQB-1:0] got_data;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [SQB-1:0] rnd256();
      logic [SQB-1:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      rr = 0; mvalid = 0; mdata = '0; mode = 0; merr = 2'b00;
      last_ready = '0; last_cq_ready = 1'b1;
   endtask

   task automatic step();
      int w, v;
      logic [N-1:0]   er, ecv;
      logic           ecr, ack_ok, all_zero;
      logic [SQB-1:0] d;
      #4;
      w = -1;
      if (mode == 0 && (!mvalid || m_sq_ready))
         for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (w < 0 && s_sq_valid[j] && mcnt[j] < MO) w = j;
         end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      v = int'(s_cq_data[3:0]);
      ecv = '0; ecr = 1'b1; ack_ok = 1'b0;
      if (v < N) begin
         ecr = m_cq_ready[v];
         ecv[v] = s_cq_valid;
         ack_ok = s_cq_valid && m_cq_ready[v];
      end
      got_ready = s_sq_ready; got_drained = drained; got_err = err_sticky; got_data = m_sq_data;
      check("sq_ready", s_sq_ready, er);
      check("m_sq_valid", m_sq_valid, mvalid);
      if (mvalid) check("m_sq_data", m_sq_data, mdata);
      check("m_cq_valid", m_cq_valid, ecv);
      check("s_cq_ready", s_cq_ready, ecr);
      check("m_cq_data", m_cq_data, s_cq_data);
      check("drained", drained, mode == 2);
      check("err_sticky", err_sticky, merr);
      all_zero = 1'b1;
      for (int i = 0; i < N; i++) if (mcnt[i] != 0) all_zero = 1'b0;
      if (mode == 0 && drain_req) mode = 1;
      else if (mode == 1 && !drain_req) mode = 0;
      else if (mode == 1 && !mvalid && all_zero) mode = 2;
      else if (mode == 2 && !drain_req) mode = 0;
      if (s_cq_valid && v >= N) merr[1] = 1'b1;
      if (ack_ok && mcnt[v] == 0) merr[0] = 1'b1;
      if (w >= 0) begin
         d = s_sq_data[w*SQB +: SQB];
         d[3:0] = 4'(w);
         mdata = d; mvalid = 1; rr = (w + 1) % N;
      end else if (m_sq_ready) mvalid = 0;
      for (int i = 0; i < N; i++) begin
         bit inc, dec;
         inc = (w == i);
         dec = ack_ok && (v == i);
         if (inc && !dec) mcnt[i]++;
         else if (dec && !inc && mcnt[i] > 0) mcnt[i]--;
      end
      last_ready = er; last_cq_ready = ecr;
      @(posedge aclk); #1;
      for (int i = 0; i < N; i++) if (last_ready[i]) s_sq_data[i*SQB +: SQB] = rnd256();
   endtask

   task automatic inputs_idle();
      s_sq_valid = '0; m_sq_ready = 1'b0; s_cq_valid = 1'b0; m_cq_ready = '0; drain_req = 1'b0;
      s_cq_data = '0;
      for (int i = 0; i < N; i++) s_sq_data[i*SQB +: SQB] = rnd256();
   endtask

   task automatic apply_reset();
      inputs_idle();
      aresetn = 1'b0;
      #2;
      check("rst_m_sq_valid", m_sq_valid, 1'b0);
      check("rst_m_cq_valid", m_cq_valid, '0);
      check("rst_drained", drained, 1'b0);
      check("rst_err", err_sticky, 2'b00);
      repeat (2) @(posedge aclk);
      @(negedge aclk); aresetn = 1'b1;
      @(posedge aclk); #1;
      model_reset();
   endtask

   task automatic send_ack(input int vf, input logic [N-1:0] rdy);
      s_cq_valid = 1'b1; s_cq_data = {$urandom}; s_cq_data[3:0] = 4'(vf); m_cq_ready = rdy;
      step();
      s_cq_valid = 1'b0;
   endtask

   initial begin
      logic [N-1:0] exp1;
      aresetn = 1'b1;
      apply_reset();

      // single requester, back-to-back
      s_sq_valid = 4'b0001; m_sq_ready = 1'b1;
      repeat (3) begin step(); check("single_grant", got_ready, 4'b0001); end
      s_sq_valid = '0;
      step(); check("single_vfid", got_data[3:0], 4'd0);

      // all requesters: strict rotation
      apply_reset();
      s_sq_valid = '1; m_sq_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(); exp1 = '0; exp1[k % N] = 1'b1; check("rr_order", got_ready, exp1);
      end

      // credit exhaustion on requester 2
      apply_reset();
      s_sq_valid = 4'b0100; m_sq_ready = 1'b1;
      repeat (16) step();
      s_sq_valid = 4'b0101;
      repeat (4) begin step(); check("credit_mask", got_ready[2], 1'b0); end
      send_ack(2, '1);
      step(); check("credit_reenable", got_ready, 4'b0100);

      // output stall
      apply_reset();
      s_sq_valid = 4'b0001; m_sq_ready = 1'b0;
      step();
      repeat (5) begin step(); check("stall_no_grant", got_ready, 4'b0000); end
      m_sq_ready = 1'b1;
      step(); check("stall_release_grant", got_ready, 4'b0001);

      // error flags
      apply_reset();
      send_ack(7, '0);
      step(); check("err_range", got_err, 2'b10);
      send_ack(1, '1);
      step(); check("err_underflow", got_err, 2'b11);

      // drain with two outstanding on requester 1
      apply_reset();
      s_sq_valid = 4'b0010; m_sq_ready = 1'b1;
      repeat (2) step();
      s_sq_valid = '0; drain_req = 1'b1;
      step();
      s_sq_valid = '1;
      repeat (3) begin step(); check("drain_no_grant", got_ready, 4'b0000); end
      send_ack(1, '1);
      step();
      send_ack(1, '1);
      step(); check("drain_not_yet", got_drained, 1'b0);
      step(); check("drain_done", got_drained, 1'b1);
      drain_req = 1'b0;
      step();
      step(); check("drain_resume", got_ready, 4'b0100);

      // randomized traffic
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) apply_reset();
         for (int i = 0; i < N; i++)
            if (!s_sq_valid[i] || last_ready[i]) begin
               s_sq_valid[i] = ($urandom % 3) != 0;
               s_sq_data[i*SQB +: SQB] = rnd256();
            end
         if (!s_cq_valid || last_cq_ready) begin
            s_cq_valid = $urandom % 2;
            s_cq_data = $urandom;
            s_cq_data[3:0] = (($urandom % 10) == 0) ? 4'($urandom % 16) : 4'($urandom % N);
         end
         m_cq_ready = N'($urandom);
         m_sq_ready = ($urandom % 4) != 0;
         drain_req = (c % 400) >= 300;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
